// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with MEM/WB operand forwarding,
// load-use hazard detection and ALU operand selection behind a valid/ready handshake.
// Optional build macro ID_EX_PERF_COUNTERS_EN adds the stall_count and bubble_count outputs.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data,
    input  logic [DATA_WIDTH-1:0]     in_rs2_data,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [CTRL_WIDTH-1:0]     in_alu_control,
    input  logic                      in_branch_op,
    input  logic [1:0]                in_a_sel,
    input  logic [1:0]                in_b_sel,
    input  logic                      in_reg_write,
    input  logic                      in_mem_read,
    input  logic                      in_mem_write,
    input  logic                      flush,
    input  logic                      fwd_mem_valid,
    input  logic                      fwd_mem_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_mem_rd,
    input  logic [DATA_WIDTH-1:0]     fwd_mem_data,
    input  logic                      fwd_wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] fwd_wb_rd,
    input  logic [DATA_WIDTH-1:0]     fwd_wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     operand_A,
    output logic [DATA_WIDTH-1:0]     operand_B,
    output logic [CTRL_WIDTH-1:0]     ALU_Control,
    output logic                      branch_op,
    output logic [DATA_WIDTH-1:0]     out_store_data,
    output logic [DATA_WIDTH-1:0]     out_pc,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_reg_write,
    output logic                      out_mem_read,
    output logic                      out_mem_write,
    output logic                      load_use_stall
`ifdef ID_EX_PERF_COUNTERS_EN
    ,
    output logic [31:0]               stall_count,
    output logic [31:0]               bubble_count
`endif
);
    logic                      held_valid_q, held_valid_d;
    logic [DATA_WIDTH-1:0]     pc_q, pc_d, imm_q, imm_d;
    logic [DATA_WIDTH-1:0]     rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CTRL_WIDTH-1:0]     alu_control_q, alu_control_d;
    logic [1:0]                a_sel_q, a_sel_d, b_sel_q, b_sel_d;
    logic                      branch_op_q, branch_op_d, reg_write_q, reg_write_d;
    logic                      mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [DATA_WIDTH-1:0]     rs1_fwd, rs2_fwd;
    logic                      rs1_used, rs2_used, consume, capture;

    // Register 0 reads as zero; a MEM load has no data yet so only WB can supply it
    function automatic logic [DATA_WIDTH-1:0] forward(input logic [REG_ADDR_WIDTH-1:0] src,
                                                      input logic [DATA_WIDTH-1:0]     rf);
        return (src == '0) ? '0 :
               (fwd_mem_valid && !fwd_mem_is_load && fwd_mem_rd == src) ? fwd_mem_data :
               (fwd_wb_valid && fwd_wb_rd == src) ? fwd_wb_data : rf;
    endfunction

    // Live forwarding onto the held entry, hazard detection, handshake and operand muxing
    always_comb begin
        rs1_fwd        = forward(rs1_q, rs1_data_q);
        rs2_fwd        = forward(rs2_q, rs2_data_q);
        rs1_used       = a_sel_q == 2'd0;
        rs2_used       = b_sel_q == 2'd0 || mem_write_q;
        load_use_stall = held_valid_q && fwd_mem_valid && fwd_mem_is_load && fwd_mem_rd != '0 &&
                         ((rs1_used && fwd_mem_rd == rs1_q) || (rs2_used && fwd_mem_rd == rs2_q));
        out_valid      = held_valid_q && !load_use_stall;
        in_ready       = !held_valid_q || (out_ready && !load_use_stall);
        consume        = out_valid && out_ready;
        capture        = in_valid && in_ready && !flush;
        operand_A      = a_sel_q == 2'd0 ? rs1_fwd : a_sel_q == 2'd1 ? pc_q : '0;
        operand_B      = b_sel_q == 2'd0 ? rs2_fwd : b_sel_q == 2'd1 ? imm_q :
                         b_sel_q == 2'd2 ? DATA_WIDTH'(4) : '0;
        out_store_data = rs2_fwd;
    end

    // Next state: flush beats capture beats hold; held operands absorb forwarded results each cycle
    always_comb begin
        held_valid_d  = flush ? 1'b0 : capture ? 1'b1 : consume ? 1'b0 : held_valid_q;
        pc_d          = capture ? in_pc : pc_q;
        imm_d         = capture ? in_imm : imm_q;
        rs1_d         = capture ? in_rs1 : rs1_q;
        rs2_d         = capture ? in_rs2 : rs2_q;
        rd_d          = capture ? in_rd : rd_q;
        rs1_data_d    = capture ? forward(in_rs1, in_rs1_data) : rs1_fwd;
        rs2_data_d    = capture ? forward(in_rs2, in_rs2_data) : rs2_fwd;
        alu_control_d = capture ? in_alu_control : alu_control_q;
        a_sel_d       = capture ? in_a_sel : a_sel_q;
        b_sel_d       = capture ? in_b_sel : b_sel_q;
        branch_op_d   = capture ? in_branch_op : branch_op_q;
        reg_write_d   = capture ? in_reg_write : reg_write_q;
        mem_read_d    = capture ? in_mem_read : mem_read_q;
        mem_write_d   = capture ? in_mem_write : mem_write_q;
    end

    // Stage register with synchronous active-low reset that also drops any held instruction
    always_ff @(posedge clock) begin
        if (!reset) begin
            held_valid_q  <= 1'b0;
            pc_q          <= '0;
            imm_q         <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            alu_control_q <= '0;
            a_sel_q       <= '0;
            b_sel_q       <= '0;
            branch_op_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            held_valid_q  <= held_valid_d;
            pc_q          <= pc_d;
            imm_q         <= imm_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            alu_control_q <= alu_control_d;
            a_sel_q       <= a_sel_d;
            b_sel_q       <= b_sel_d;
            branch_op_q   <= branch_op_d;
            reg_write_q   <= reg_write_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
        end
    end

    assign ALU_Control   = alu_control_q;
    assign branch_op     = branch_op_q;
    assign out_pc        = pc_q;
    assign out_rd        = rd_q;
    assign out_reg_write = reg_write_q;
    assign out_mem_read  = mem_read_q;
    assign out_mem_write = mem_write_q;

`ifdef ID_EX_PERF_COUNTERS_EN
    logic [31:0] stall_count_q, stall_count_d, bubble_count_q, bubble_count_d;

    // Backpressure and hazard-bubble cycle counts, wrapping at 2^32
    always_comb begin
        stall_count_d  = stall_count_q + 32'(held_valid_q && !out_ready && !load_use_stall);
        bubble_count_d = bubble_count_q + 32'(load_use_stall);
    end

    // Counters clear only on reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            stall_count_q  <= stall_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign stall_count  = stall_count_q;
    assign bubble_count = bubble_count_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven directed checks of id_ex_stage, one record per clock cycle.
module tb_id_ex_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_branch_op, in_reg_write, in_mem_read, in_mem_write;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [5:0]  in_alu_control;
    logic [1:0]  in_a_sel, in_b_sel;
    logic        flush, fwd_mem_valid, fwd_mem_is_load, fwd_wb_valid;
    logic [4:0]  fwd_mem_rd, fwd_wb_rd;
    logic [31:0] fwd_mem_data, fwd_wb_data;
    logic        out_valid, out_ready, branch_op, out_reg_write, out_mem_read, out_mem_write;
    logic [31:0] operand_A, operand_B, out_store_data, out_pc;
    logic [5:0]  ALU_Control;
    logic [4:0]  out_rd;
    logic        load_use_stall;

    int n_chk = 0;
    int n_fail = 0;

    id_ex_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_alu_control(in_alu_control),
        .in_branch_op(in_branch_op), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_reg_write(in_reg_write), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .flush(flush), .fwd_mem_valid(fwd_mem_valid), .fwd_mem_is_load(fwd_mem_is_load),
        .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data), .fwd_wb_valid(fwd_wb_valid),
        .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data), .out_valid(out_valid),
        .out_ready(out_ready), .operand_A(operand_A), .operand_B(operand_B),
        .ALU_Control(ALU_Control), .branch_op(branch_op), .out_store_data(out_store_data),
        .out_pc(out_pc), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .load_use_stall(load_use_stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n, in_valid, flush, out_ready;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [5:0]  alu;
        logic [1:0]  as, bs;
        logic [3:0]  ctl;
        logic        mv, ml, wv;
        logic [4:0]  mrd, wrd;
        logic [31:0] mdata, wdata;
        logic        e_rdy, e_vld, e_stall, full;
        logic [31:0] e_a, e_b, e_st, e_pc;
        logic [5:0]  e_alu;
        logic [4:0]  e_rd;
        logic [3:0]  e_ctl;
    } vec_t;

    function automatic vec_t nop();
        vec_t v;
        v.rst_n = 1; v.in_valid = 0; v.flush = 0; v.out_ready = 1;
        v.pc = 0; v.d1 = 0; v.d2 = 0; v.imm = 0; v.rs1 = 0; v.rs2 = 0; v.rd = 0;
        v.alu = 0; v.as = 0; v.bs = 0; v.ctl = 0;
        v.mv = 0; v.ml = 0; v.mrd = 0; v.mdata = 0; v.wv = 0; v.wrd = 0; v.wdata = 0;
        v.e_rdy = 1; v.e_vld = 0; v.e_stall = 0; v.full = 0;
        v.e_a = 0; v.e_b = 0; v.e_st = 0; v.e_pc = 0; v.e_alu = 0; v.e_rd = 0; v.e_ctl = 0;
        return v;
    endfunction

    // ctl packs {branch_op, reg_write, mem_read, mem_write}
    function automatic vec_t ins(vec_t vi, int pc, int rs1, int d1, int rs2, int d2, int imm,
                                 int as, int bs, int alu, int rd, int ctl);
        vec_t v = vi;
        v.in_valid = 1; v.pc = 32'(pc); v.rs1 = 5'(rs1); v.d1 = 32'(d1); v.rs2 = 5'(rs2);
        v.d2 = 32'(d2); v.imm = 32'(imm); v.as = 2'(as); v.bs = 2'(bs); v.alu = 6'(alu);
        v.rd = 5'(rd); v.ctl = 4'(ctl);
        return v;
    endfunction

    function automatic vec_t mem(vec_t vi, int ld, int rd, int data);
        vec_t v = vi;
        v.mv = 1; v.ml = 1'(ld); v.mrd = 5'(rd); v.mdata = 32'(data);
        return v;
    endfunction

    function automatic vec_t wb(vec_t vi, int rd, int data);
        vec_t v = vi;
        v.wv = 1; v.wrd = 5'(rd); v.wdata = 32'(data);
        return v;
    endfunction

    function automatic vec_t exv(vec_t vi, int vld, int a, int b, int st, int alu, int pc,
                                 int rd, int ctl);
        vec_t v = vi;
        v.full = 1; v.e_vld = 1'(vld); v.e_a = 32'(a); v.e_b = 32'(b); v.e_st = 32'(st);
        v.e_alu = 6'(alu); v.e_pc = 32'(pc); v.e_rd = 5'(rd); v.e_ctl = 4'(ctl);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        reset = v.rst_n; in_valid = v.in_valid; flush = v.flush; out_ready = v.out_ready;
        in_pc = v.pc; in_rs1_data = v.d1; in_rs2_data = v.d2; in_imm = v.imm;
        in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd; in_alu_control = v.alu;
        in_a_sel = v.as; in_b_sel = v.bs;
        {in_branch_op, in_reg_write, in_mem_read, in_mem_write} = v.ctl;
        fwd_mem_valid = v.mv; fwd_mem_is_load = v.ml; fwd_mem_rd = v.mrd; fwd_mem_data = v.mdata;
        fwd_wb_valid = v.wv; fwd_wb_rd = v.wrd; fwd_wb_data = v.wdata;
    endtask

    task automatic chk(input int row, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %h expected %h", row, name, act, exp);
        end
    endtask

    initial begin
        vec_t t[$];
        vec_t v;
        // 0: reset held low while decode offers an instruction
        v = nop(); v.rst_n = 0;
        v = ins(v, 'h500, 1, 'hFF, 2, 'hEE, 9, 1, 1, 'h3F, 31, 'hF);
        t.push_back(exv(v, 0, 0, 0, 0, 0, 0, 0, 0));
        // 1: capture ADD x3(5) + x4(7)
        v = ins(nop(), 'h40, 3, 5, 4, 7, 0, 0, 0, 0, 10, 'b0100);
        t.push_back(exv(v, 0, 0, 0, 0, 0, 0, 0, 0));
        // 2: ADD presented; capture B with MEM and WB both writing x6
        v = ins(nop(), 'h44, 6, 'h99, 0, 'h55, 8, 0, 1, 2, 11, 'b0100);
        v = wb(mem(v, 0, 6, 'h11), 6, 'h22);
        t.push_back(exv(v, 1, 5, 7, 7, 0, 'h40, 10, 'b0100));
        // 3: B shows MEM priority; rs2=0 gives zero store data
        t.push_back(exv(nop(), 1, 'h11, 8, 0, 2, 'h44, 11, 'b0100));
        // 4: capture C, MEM rd=0 so WB x6 wins
        v = ins(nop(), 'h48, 6, 'h99, 7, 'h77, 0, 0, 0, 3, 12, 'b0100);
        t.push_back(wb(mem(v, 0, 0, 'h11), 6, 'h22));
        // 5: C presented; capture D with rs1=rs2=0 while both stages write x0
        v = ins(nop(), 'h4C, 0, 'h1234, 0, 'h5678, 0, 0, 0, 4, 13, 'b1000);
        v = wb(mem(v, 0, 0, 'h11), 0, 'h22);
        t.push_back(exv(v, 1, 'h22, 'h77, 'h77, 3, 'h48, 12, 'b0100));
        // 6: D reads zero; capture E using x9 as rs2
        v = ins(nop(), 'h50, 2, 'h10, 9, 5, 0, 0, 0, 5, 14, 'b0100);
        t.push_back(exv(v, 1, 0, 0, 0, 4, 'h4C, 13, 'b1000));
        // 7: MEM load to x9 -> bubble, F must wait
        v = mem(ins(nop(), 'h54, 8, 'h100, 1, 3, 'h20, 0, 1, 6, 15, 'b0100), 1, 9, 'hDEAD);
        v.e_rdy = 0; v.e_stall = 1;
        t.push_back(v);
        // 8: load data arrives from WB; E released and F captured
        v = wb(ins(nop(), 'h54, 8, 'h100, 1, 3, 'h20, 0, 1, 6, 15, 'b0100), 9, 'hABCD);
        t.push_back(exv(v, 1, 'h10, 'hABCD, 'hABCD, 5, 'h50, 14, 'b0100));
        // 9-11: backpressure while WB keeps writing x8
        v = wb(ins(nop(), 'h100, 0, 0, 0, 0, 0, 1, 2, 7, 1, 'b0100), 8, 'h200);
        v.out_ready = 0; v = exv(v, 1, 'h200, 'h20, 3, 6, 'h54, 15, 'b0100); v.e_rdy = 0;
        t.push_back(v);
        v.wv = 0;
        t.push_back(v);
        v = wb(v, 8, 'h300); v.e_a = 'h300;
        t.push_back(v);
        // 12: release with JAL waiting -> back-to-back transfer
        v = ins(nop(), 'h100, 0, 0, 0, 0, 0, 1, 2, 7, 1, 'b0100);
        t.push_back(exv(v, 1, 'h300, 'h20, 3, 6, 'h54, 15, 'b0100));
        // 13: JAL presented with no bubble (PC + 4 operands); capture store H
        v = ins(nop(), 'h200, 1, 1, 2, 2, 0, 0, 0, 8, 0, 'b0001);
        t.push_back(exv(v, 1, 'h100, 4, 0, 7, 'h100, 1, 'b0100));
        // 14: flush with a held entry and an incoming instruction
        v = ins(nop(), 'h300, 3, 3, 4, 4, 0, 0, 0, 9, 5, 'b0100); v.flush = 1;
        t.push_back(exv(v, 1, 1, 2, 2, 8, 'h200, 0, 'b0001));
        // 15: both dropped
        t.push_back(nop());
        // 16: capture store J using x5 only as store data
        t.push_back(ins(nop(), 'h60, 0, 7, 5, 7, 'h10, 2, 1, 9, 3, 'b0001));
        // 17: load to x5 stalls the store
        v = mem(nop(), 1, 5, 'hBEEF); v.e_rdy = 0; v.e_stall = 1;
        t.push_back(v);
        // 18: reset asserted mid-stall
        v.rst_n = 0;
        t.push_back(v);
        // 19: held instruction gone after reset; capture K reading x0
        v = mem(ins(nop(), 'h70, 0, 0, 0, 0, 0, 0, 0, 10, 2, 'b0000), 1, 5, 'hBEEF);
        t.push_back(exv(v, 0, 0, 0, 0, 0, 0, 0, 0));
        // 20: load to x0 never stalls
        t.push_back(exv(mem(nop(), 1, 0, 'hBEEF), 1, 0, 0, 0, 10, 'h70, 2, 'b0000));

        apply(t[0]);
        repeat (2) @(posedge clock);
        for (int i = 0; i < t.size(); i++) begin
            #1 apply(t[i]);
            @(negedge clock);
            chk(i, "in_ready", 32'(in_ready), 32'(t[i].e_rdy));
            chk(i, "out_valid", 32'(out_valid), 32'(t[i].e_vld));
            chk(i, "load_use_stall", 32'(load_use_stall), 32'(t[i].e_stall));
            if (t[i].full) begin
                chk(i, "operand_A", operand_A, t[i].e_a);
                chk(i, "operand_B", operand_B, t[i].e_b);
                chk(i, "store_data", out_store_data, t[i].e_st);
                chk(i, "ALU_Control", 32'(ALU_Control), 32'(t[i].e_alu));
                chk(i, "out_pc", out_pc, t[i].e_pc);
                chk(i, "out_rd", 32'(out_rd), 32'(t[i].e_rd));
                chk(i, "ctl", 32'({branch_op, out_reg_write, out_mem_read, out_mem_write}),
                    32'(t[i].e_ctl));
            end
            @(posedge clock);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register sitting directly upstream of the ALU.
- Latches decoded instruction fields and applies operand forwarding from the MEM and WB stages.
- Selects the ALU operand sources and detects load-use hazards.
- Drives operand_A, operand_B, ALU_Control and branch_op to the ALU with a valid/ready handshake.

Parameters:
DATA_WIDTH, 32, width of PC, register data, immediate and operands
REG_ADDR_WIDTH, 5, register index width
CTRL_WIDTH, 6, ALU control code width

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous reset, active-low (asserted when 0)
in_valid  input  1  decode presents an instruction
in_ready  output  1  stage can accept this cycle
in_pc  input  DATA_WIDTH  instruction PC
in_rs1_data  input  DATA_WIDTH  register file read data, rs1
in_rs2_data  input  DATA_WIDTH  register file read data, rs2
in_imm  input  DATA_WIDTH  sign-extended immediate
in_rs1, in_rs2, in_rd  input  REG_ADDR_WIDTH  source and destination indices
in_alu_control  input  CTRL_WIDTH  ALU operation code
in_branch_op  input  1  instruction is a conditional branch
in_a_sel  input  2  operand_A source: 0 rs1, 1 PC, 2 zero, 3 reserved (treated as zero)
in_b_sel  input  2  operand_B source: 0 rs2, 1 imm, 2 constant 4, 3 reserved (treated as zero)
in_reg_write, in_mem_read, in_mem_write  input  1  downstream control bits
flush  input  1  kill the held and incoming instruction
fwd_mem_valid  input  1  MEM stage writes a register
fwd_mem_is_load  input  1  MEM stage instruction is a load (data not yet available)
fwd_mem_rd  input  REG_ADDR_WIDTH  MEM stage destination index
fwd_mem_data  input  DATA_WIDTH  MEM stage result
fwd_wb_valid  input  1  WB stage writes a register
fwd_wb_rd  input  REG_ADDR_WIDTH  WB stage destination index
fwd_wb_data  input  DATA_WIDTH  WB stage result
out_valid  output  1  ALU inputs valid
out_ready  input  1  execute stage accepts
operand_A, operand_B  output  DATA_WIDTH  ALU operands
ALU_Control  output  CTRL_WIDTH  registered in_alu_control
branch_op  output  1  registered in_branch_op
out_store_data  output  DATA_WIDTH  forwarded rs2 value, used for stores
out_pc  output  DATA_WIDTH  registered PC
out_rd  output  REG_ADDR_WIDTH  registered destination index
out_reg_write, out_mem_read, out_mem_write  output  1  registered control bits
load_use_stall  output  1  hazard bubble active

Behaviour:
- Single-entry stage; 1-cycle latency from capture to out_valid.
- in_ready = !held_valid || (out_ready && !load_use_stall); combinational.
- Capture occurs when in_valid && in_ready && !flush. If no capture occurs but the held entry is consumed, held_valid clears.
- Forwarding at capture:
  - Per source, MEM is used if fwd_mem_valid && !fwd_mem_is_load && fwd_mem_rd==src && src!=0.
  - Otherwise WB is used if fwd_wb_valid && fwd_wb_rd==src && src!=0.
  - Otherwise the register file data is used.
- While held (stalled or hazard), the stored rs1/rs2 data are re-forwarded every cycle with the same priority. No update is lost.
- Source index 0 always yields 0, regardless of register file data or forwarding.
- Load-use hazard:
  - load_use_stall = held_valid && fwd_mem_valid && fwd_mem_is_load && fwd_mem_rd!=0 && (fwd_mem_rd matches a source the instruction uses).
  - rs1 is used when a_sel==0. rs2 is used when b_sel==0 or mem_write.
  - During the hazard, out_valid = 0, the entry is held and in_ready = 0.
  - The hazard resolves when the load reaches WB and its data is forwarded into the held entry.
- out_valid = held_valid && !load_use_stall.
- Operand muxing is combinational from held state per in_a_sel/in_b_sel. The constant-4 source is used for JAL/JALR link computation.
- Flush:
  - held_valid clears on the next edge.
  - A same-cycle capture is discarded; flush wins over capture and over hold.
  - in_ready is unaffected by flush.
- Reset (reset==0 at a clock edge):
  - All registered outputs go to 0, held_valid = 0, out_valid = 0, load_use_stall = 0.
  - Reset mid-stall drops the held instruction.
- Simultaneous consume and capture: the new instruction replaces the old with no bubble.
- Width rules: no arithmetic in this block, except the constant 4, which is zero-extended to DATA_WIDTH.

Optional Feature:
- Macro: ID_EX_PERF_COUNTERS_EN.
- When defined, two 32-bit output ports are added:
  - stall_count: increments each cycle held_valid && !out_ready && !load_use_stall.
  - bubble_count: increments each cycle load_use_stall.
- Both counters wrap at 2^32 and clear on reset; flush does not clear them.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset low for 2 cycles, in_valid=1 → out_valid=0 and all outputs 0; after release, in_ready=1.
- ADD capture: rs1=3 (data 5), rs2=4 (data 7), a_sel=0, b_sel=0, ALU_Control=0 → next cycle operand_A=5, operand_B=7, out_valid=1.
- Forward priority: rs1=6, MEM rd=6 data 0x11, WB rd=6 data 0x22 → operand_A=0x11. Same with MEM rd=0 → 0x22. With rs1=0 → 0.
- Load-use: held instruction uses rs2=9 while MEM is a load with rd=9 → one cycle of out_valid=0, load_use_stall=1, in_ready=0. Next cycle WB rd=9 data 0xABCD → operand_B=0xABCD, out_valid=1.
- Backpressure: out_ready=0 for 3 cycles while WB writes rs1 → held operand_A updates, in_ready=0. out_ready=1 with a new in_valid → back-to-back transfer with no bubble.
- Flush with in_valid=1 and a held entry → next cycle out_valid=0. JAL with a_sel=1, b_sel=2, PC=0x100 → operand_A=0x100, operand_B=4.
